// File: rtl/ocdm_stream_pkg.sv
// Shared types for the complex sample stream: per-beat payload layout,
// field widths and the receive-side framing state encoding.
package ocdm_stream_pkg;

  localparam int unsigned IBW = 16;
  localparam int unsigned MW  = 3;

  typedef struct packed {
    logic           tlast;
    logic [IBW-1:0] re;
    logic [IBW-1:0] im;
    logic           tfirst;
    logic           cfg_tvalid;
    logic [MW-1:0]  cfg_mod;
  } cmplx_beat_t;

  localparam int unsigned BEAT_W = $bits(cmplx_beat_t);

  typedef enum logic {
    FRM_IDLE   = 1'b0,
    FRM_IN_PKT = 1'b1
  } frm_state_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cmplx_fifo_mem.sv
// Beat storage: DEPTH x BEAT_W register array, one synchronous write port
// and one asynchronous read port for first-word-fall-through replay.
module cmplx_fifo_mem
  import ocdm_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BEAT_W-1:0] rd_data_c
);

  logic [BEAT_W-1:0] mem [DEPTH];

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/cmplx_stream_skid_fifo.sv
// Receive-side elastic buffer catching beats the fixed-latency delay line
// emits after s_tready drops, replayed with a valid/ready handshake.
module cmplx_stream_skid_fifo
  import ocdm_stream_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic                  s_tfirst,
  input  logic [IBW-1:0]        s_bus_re,
  input  logic [IBW-1:0]        s_bus_im,
  input  logic                  s_cfg_tvalid,
  input  logic [MW-1:0]         s_cfg_modulation,
  output logic                  s_tready,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tfirst,
  output logic [IBW-1:0]        m_bus_re,
  output logic [IBW-1:0]        m_bus_im,
  output logic                  m_cfg_tvalid,
  output logic [MW-1:0]         m_cfg_modulation,
  output logic [$clog2(DEPTH):0] count,
  output logic                  ovf_err,
  output logic                  frm_err
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_c;
  logic          rd_c;
  logic          ovf_c;
  logic [CW-1:0] count_next_c;
  frm_state_t    frm_state;
  frm_state_t    frm_state_next;
  logic          frm_viol_c;
  cmplx_beat_t   wr_beat;
  cmplx_beat_t   rd_beat;

  assign rd_c         = m_tvalid & m_tready;
  assign wr_c         = s_tvalid & ((count != FULL_LVL) | rd_c);
  assign ovf_c        = s_tvalid & ~wr_c;
  assign count_next_c = count + CW'(wr_c) - CW'(rd_c);

  assign wr_beat = '{tlast:      s_tlast,
                     re:         s_bus_re,
                     im:         s_bus_im,
                     tfirst:     s_tfirst,
                     cfg_tvalid: s_cfg_tvalid,
                     cfg_mod:    s_cfg_modulation};

  cmplx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en     (wr_c),
    .wr_addr   (wr_ptr),
    .wr_data   (wr_beat),
    .rd_addr   (rd_ptr),
    .rd_data_c (rd_beat)
  );

  assign m_tlast          = rd_beat.tlast;
  assign m_tfirst         = rd_beat.tfirst;
  assign m_bus_re         = rd_beat.re;
  assign m_bus_im         = rd_beat.im;
  assign m_cfg_tvalid     = rd_beat.cfg_tvalid;
  assign m_cfg_modulation = rd_beat.cfg_mod;

  // Framing: only beats actually written are checked; dropped beats are ignored.
  always_comb begin
    frm_state_next = frm_state;
    frm_viol_c     = 1'b0;
    if (wr_c) begin
      frm_viol_c = (frm_state == FRM_IN_PKT) ? s_tfirst : ~s_tfirst;
      if (s_tlast)       frm_state_next = FRM_IDLE;
      else if (s_tfirst) frm_state_next = FRM_IN_PKT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      ovf_err   <= 1'b0;
      frm_err   <= 1'b0;
      frm_state <= FRM_IDLE;
    end else begin
      if (wr_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_c) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next_c;
      s_tready  <= (count_next_c < AFULL_LVL);
      m_tvalid  <= (count_next_c != '0);
      frm_state <= frm_state_next;
      if (ovf_c)      ovf_err <= 1'b1;
      if (frm_viol_c) frm_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmplx_stream_skid_fifo.sv
// Self-checking bench: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations and random traffic.
module tb_cmplx_stream_skid_fifo;
  import ocdm_stream_pkg::*;

  localparam int unsigned DEPTH        = 8;
  localparam int unsigned AFULL_MARGIN = 3;

  logic           clk = 1'b0;
  logic           rstn;
  logic           s_tvalid, s_tlast, s_tfirst, s_cfg_tvalid;
  logic [IBW-1:0] s_bus_re, s_bus_im;
  logic [MW-1:0]  s_cfg_modulation;
  logic           s_tready, m_tvalid, m_tready;
  logic           m_tlast, m_tfirst, m_cfg_tvalid;
  logic [IBW-1:0] m_bus_re, m_bus_im;
  logic [MW-1:0]  m_cfg_modulation;
  logic [3:0]     count;
  logic           ovf_err, frm_err;

  int n_cmp  = 0;
  int n_fail = 0;

  cmplx_stream_skid_fifo #(
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_tvalid         (s_tvalid),
    .s_tlast          (s_tlast),
    .s_tfirst         (s_tfirst),
    .s_bus_re         (s_bus_re),
    .s_bus_im         (s_bus_im),
    .s_cfg_tvalid     (s_cfg_tvalid),
    .s_cfg_modulation (s_cfg_modulation),
    .s_tready         (s_tready),
    .m_tvalid         (m_tvalid),
    .m_tready         (m_tready),
    .m_tlast          (m_tlast),
    .m_tfirst         (m_tfirst),
    .m_bus_re         (m_bus_re),
    .m_bus_im         (m_bus_im),
    .m_cfg_tvalid     (m_cfg_tvalid),
    .m_cfg_modulation (m_cfg_modulation),
    .count            (count),
    .ovf_err          (ovf_err),
    .frm_err          (frm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of beats plus the sticky flags and packet state.
  cmplx_beat_t mq[$];
  logic exp_ovf = 1'b0, exp_frm = 1'b0, exp_inpkt = 1'b0, exp_sready = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      exp_ovf = 1'b0; exp_frm = 1'b0; exp_inpkt = 1'b0; exp_sready = 1'b0;
    end else begin
      bit rd, wr;
      cmplx_beat_t b;
      rd = (mq.size() > 0) && m_tready;
      wr = s_tvalid && ((mq.size() < DEPTH) || rd);
      if (rd) void'(mq.pop_front());
      if (s_tvalid && !wr) exp_ovf = 1'b1;
      if (wr) begin
        if (exp_inpkt == s_tfirst) exp_frm = 1'b1;
        if (s_tlast) exp_inpkt = 1'b0;
        else if (s_tfirst) exp_inpkt = 1'b1;
        b.tlast = s_tlast; b.re = s_bus_re; b.im = s_bus_im; b.tfirst = s_tfirst;
        b.cfg_tvalid = s_cfg_tvalid; b.cfg_mod = s_cfg_modulation;
        mq.push_back(b);
      end
      exp_sready = (mq.size() < DEPTH - AFULL_MARGIN);
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    check("count", 64'(count), 64'(mq.size()));
    check("m_tvalid", 64'(m_tvalid), 64'(mq.size() > 0));
    check("s_tready", 64'(s_tready), 64'(exp_sready));
    check("ovf_err", 64'(ovf_err), 64'(exp_ovf));
    check("frm_err", 64'(frm_err), 64'(exp_frm));
    if (mq.size() > 0)
      check("head_beat",
            64'({m_tlast, m_bus_re, m_bus_im, m_tfirst, m_cfg_tvalid, m_cfg_modulation}),
            64'(mq[0]));
  end

  task automatic drive(input logic v, input logic f, input logic l,
                       input logic [IBW-1:0] re, input logic [IBW-1:0] im,
                       input logic [MW-1:0] md, input logic rdy);
    @(negedge clk);
    s_tvalid = v; s_tfirst = f; s_tlast = l; s_bus_re = re; s_bus_im = im;
    s_cfg_tvalid = v; s_cfg_modulation = md; m_tready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  // Packets of four beats: tfirst on index%4==0, tlast on index%4==3.
  task automatic pkt_beat(input int idx, input logic rdy);
    drive(1'b1, (idx % 4) == 0, (idx % 4) == 3, IBW'(16'h100 + idx), IBW'(16'h8000 ^ idx),
          MW'(idx), rdy);
  endtask

  initial begin
    rstn = 1'b0;
    s_tvalid = 0; s_tfirst = 0; s_tlast = 0; s_bus_re = '0; s_bus_im = '0;
    s_cfg_tvalid = 0; s_cfg_modulation = '0; m_tready = 0;
    repeat (2) @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_s_tready", 64'(s_tready), 64'd1);

    // 4-beat packet straight through with the consumer always ready
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, i == 3, IBW'(i + 1), IBW'(-(i + 1)), MW'(i), 1'b1);
      if (i == 1) begin
        check("t1_head_re", 64'(m_bus_re), 64'd1);
        check("t1_head_im", 64'(m_bus_im), 64'hFFFF);
        check("t1_count", 64'(count), 64'd1);
      end
    end
    idle(1'b1);
    check("t1_last_re", 64'(m_bus_re), 64'd4);
    check("t1_last_flag", 64'(m_tlast), 64'd1);
    idle(1'b1);
    check("t1_empty", 64'(m_tvalid), 64'd0);

    // Fill with consumer stalled: almost-full after the fifth beat
    for (int i = 0; i < 8; i++) begin
      pkt_beat(i, 1'b0);
      if (i == 5) check("t2_afull", 64'(s_tready), 64'd0);
    end
    pkt_beat(8, 1'b0);
    check("t2_full_count", 64'(count), 64'd8);
    check("t2_no_ovf", 64'(ovf_err), 64'd0);
    idle(1'b0);
    check("t3_ovf", 64'(ovf_err), 64'd1);
    check("t3_count", 64'(count), 64'd8);
    repeat (9) idle(1'b1);
    check("t3_drained", 64'(count), 64'd0);

    // Full with simultaneous read and write across pointer wrap
    for (int i = 0; i < 8; i++) pkt_beat(i, 1'b0);
    for (int i = 8; i < 28; i++) pkt_beat(i, 1'b1);
    idle(1'b0);
    check("t4_count", 64'(count), 64'd8);
    check("t4_frm_clean", 64'(frm_err), 64'd0);
    repeat (9) idle(1'b1);

    // Framing: tfirst, mid, tfirst, then a single-beat packet
    drive(1'b1, 1'b1, 1'b0, 16'h11, 16'h21, 3'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 16'h12, 16'h22, 3'd2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h13, 16'h23, 3'd3, 1'b0);
    check("t5_frm_before", 64'(frm_err), 64'd0);
    drive(1'b1, 1'b1, 1'b1, 16'h14, 16'h24, 3'd4, 1'b0);
    check("t5_frm_set", 64'(frm_err), 64'd1);
    idle(1'b0);
    check("t5_frm_sticky", 64'(frm_err), 64'd1);
    repeat (6) idle(1'b1);

    // Random traffic; upstream mostly honours s_tready but sometimes overruns
    for (int c = 0; c < 1500; c++) begin
      logic v;
      v = s_tready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      drive(v, 1'($urandom), 1'($urandom), IBW'($urandom), IBW'($urandom),
            MW'($urandom), 1'($urandom));
    end
    repeat (10) idle(1'b1);

    // Asynchronous reset in the middle of a drain with five entries held
    for (int i = 0; i < 7; i++) pkt_beat(i, 1'b0);
    repeat (2) idle(1'b1);
    idle(1'b0);
    check("t6_pre_count", 64'(count), 64'd5);
    #2 rstn = 1'b0;
    #1;
    check("t6_async_count", 64'(count), 64'd0);
    check("t6_async_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_async_s_tready", 64'(s_tready), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1 check("t6_rel_s_tready_low", 64'(s_tready), 64'd0);
    @(negedge clk);
    check("t6_rel_s_tready", 64'(s_tready), 64'd1);
    check("t6_rel_m_tvalid", 64'(m_tvalid), 64'd0);
    repeat (3) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
